dtc_vote_window: RTL and testbench

- Downstream stage for the 12-input / 3-bit-class decision-tree classifier.
- Takes the classifier's per-sample class predictions over a valid/ready stream and keeps a sliding window of the last WINDOW predictions.
- Emits the majority (mode) class of that window, registered, with backpressure, so single-sample misclassifications are smoothed before the system consumes the result.

---
 rtl/dtc_vote_pkg.sv | 26 ++
 rtl/dtc_vote_argmax.sv | 31 +++
 rtl/dtc_vote_window.sv | 173 +++++++++++++++++
 tb/tb_dtc_vote_window.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dtc_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtc_vote_pkg
// Desc     : Shared types and helpers for the decision-tree vote window.
// Revision : 1.0  initial release
// ============================================================================
package dtc_vote_pkg;

    // Class code width produced by the upstream classifier
    localparam int DEF_CLASS_W = 3;

    typedef logic [DEF_CLASS_W-1:0] cls_t;

    // FILL: window not yet complete; RUN: window full, sliding
    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } vote_state_e;

    // Width of a counter that must hold values 0..window inclusive
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtc_vote_argmax.sv
`default_nettype none
// ============================================================================
// Module   : dtc_vote_argmax
// Desc     : Combinational argmax over NUM_CLS packed counters; ties go to
//            the lowest class index.
// Revision : 1.0  initial release
// ============================================================================
module dtc_vote_argmax #(
    parameter int NUM_CLS = 8,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_CLS*CNT_W-1:0] cnt_flat,
    output logic [IDX_W-1:0]         win_idx,
    output logic [CNT_W-1:0]         win_cnt
);

    // Linear scan; strict greater-than keeps the earliest index on a tie
    always_comb begin
        win_idx = '0;
        win_cnt = cnt_flat[CNT_W-1:0];
        for (int i = 1; i < NUM_CLS; i++) begin
            if (cnt_flat[i*CNT_W +: CNT_W] > win_cnt) begin
                win_cnt = cnt_flat[i*CNT_W +: CNT_W];
                win_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtc_vote_window.sv
`default_nettype none
// ============================================================================
// Module   : dtc_vote_window
// Desc     : Sliding-window majority vote over classifier predictions with
//            valid/ready on both sides and a 1-cycle registered result.
//            Optional macro DTC_VOTE_CONF_EN adds out_conf / out_unanim.
// Revision : 1.0  initial release
// ============================================================================
module dtc_vote_window
    import dtc_vote_pkg::*;
#(
    parameter int CLASS_W = DEF_CLASS_W,
    parameter int WINDOW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CLASS_W-1:0] in_cls,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_cls,
    output logic               out_full
`ifdef DTC_VOTE_CONF_EN
    ,
    output logic [cnt_width(WINDOW)-1:0] out_conf,
    output logic                         out_unanim
`endif
);

    localparam int NUM_CLS = 2**CLASS_W;
    localparam int CNT_W   = cnt_width(WINDOW);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] WIN_FULL = CNT_W'(WINDOW);

    vote_state_e        state_q, state_d;
    logic [CLASS_W-1:0] hist_q [WINDOW];
    logic [CLASS_W-1:0] hist_d [WINDOW];
    logic [CNT_W-1:0]   cnt_q  [NUM_CLS];
    logic [CNT_W-1:0]   cnt_d  [NUM_CLS];
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic               live_q;
    logic               out_valid_q, out_valid_d;
    logic [CLASS_W-1:0] out_cls_q, out_cls_d;
    logic               out_full_q, out_full_d;

    logic                     accept;
    logic [CLASS_W-1:0]       oldest;
    logic [NUM_CLS*CNT_W-1:0] cnt_flat;
    logic [CLASS_W-1:0]       win_idx;
    logic [CNT_W-1:0]         win_cnt;

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready = live_q && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign oldest   = hist_q[WINDOW-1];

    // Window history, per-class counts, fill level and FSM next state
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        if (flush) begin
            state_d = FILL;
            fill_d  = '0;
            for (int i = 0; i < WINDOW; i++) hist_d[i] = '0;
            for (int c = 0; c < NUM_CLS; c++) cnt_d[c] = '0;
        end else if (accept) begin
            hist_d[0] = in_cls;
            for (int i = 1; i < WINDOW; i++) hist_d[i] = hist_q[i-1];
            if (state_q == FILL) begin
                cnt_d[in_cls] = cnt_q[in_cls] + ONE;
                fill_d        = fill_q + ONE;
                if (fill_q == WIN_LAST) state_d = RUN;
            end else if (in_cls != oldest) begin
                // Equal classes leave counts untouched, so skip both updates
                cnt_d[in_cls] = cnt_q[in_cls] + ONE;
                cnt_d[oldest] = cnt_q[oldest] - ONE;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CLS; g++) begin : g_flat
            assign cnt_flat[g*CNT_W +: CNT_W] = cnt_d[g];
        end
    endgenerate

    // Vote on the post-update counts so the result reflects this sample
    dtc_vote_argmax #(
        .NUM_CLS (NUM_CLS),
        .CNT_W   (CNT_W),
        .IDX_W   (CLASS_W)
    ) u_argmax (
        .cnt_flat (cnt_flat),
        .win_idx  (win_idx),
        .win_cnt  (win_cnt)
    );

`ifdef DTC_VOTE_CONF_EN
    logic [CNT_W-1:0] out_conf_q, out_conf_d;
    assign out_conf   = out_conf_q;
    assign out_unanim = (out_conf_q == WIN_FULL);
`else
    logic unused_win_cnt;
    assign unused_win_cnt = ^win_cnt;
`endif

    // Output register: load on accept, hold under backpressure, drop after handshake
    always_comb begin
        out_valid_d = out_valid_q;
        out_cls_d   = out_cls_q;
        out_full_d  = out_full_q;
`ifdef DTC_VOTE_CONF_EN
        out_conf_d  = out_conf_q;
`endif
        if (flush) begin
            out_valid_d = 1'b0;
            out_cls_d   = '0;
            out_full_d  = 1'b0;
`ifdef DTC_VOTE_CONF_EN
            out_conf_d  = '0;
`endif
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_cls_d   = win_idx;
            out_full_d  = (state_d == RUN);
`ifdef DTC_VOTE_CONF_EN
            out_conf_d  = win_cnt;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // All state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_q      <= '0;
            live_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_cls_q   <= '0;
            out_full_q  <= 1'b0;
            for (int i = 0; i < WINDOW; i++) hist_q[i] <= '0;
            for (int c = 0; c < NUM_CLS; c++) cnt_q[c] <= '0;
`ifdef DTC_VOTE_CONF_EN
            out_conf_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            live_q      <= 1'b1;
            out_valid_q <= out_valid_d;
            out_cls_q   <= out_cls_d;
            out_full_q  <= out_full_d;
            for (int i = 0; i < WINDOW; i++) hist_q[i] <= hist_d[i];
            for (int c = 0; c < NUM_CLS; c++) cnt_q[c] <= cnt_d[c];
`ifdef DTC_VOTE_CONF_EN
            out_conf_q  <= out_conf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_cls   = out_cls_q;
    assign out_full  = out_full_q;

endmodule
`default_nettype wire

// File: tb/tb_dtc_vote_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtc_vote_window
// Desc     : Scoreboard bench for dtc_vote_window; a queue-based window model
//            predicts each vote result and a negedge monitor checks the DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_dtc_vote_window;

    localparam int WINDOW  = 8;
    localparam int CLASS_W = 3;
    localparam int NUM_CLS = 2**CLASS_W;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [CLASS_W-1:0] in_cls;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_cls;
    logic               out_full;
`ifdef DTC_VOTE_CONF_EN
    logic [3:0]         out_conf;
    logic               out_unanim;
`endif

    dtc_vote_window #(
        .CLASS_W (CLASS_W),
        .WINDOW  (WINDOW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cls    (in_cls),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cls   (out_cls),
        .out_full  (out_full)
`ifdef DTC_VOTE_CONF_EN
        ,
        .out_conf  (out_conf),
        .out_unanim(out_unanim)
`endif
    );

    typedef struct {
        int cls;
        int full;
        int conf;
    } exp_t;

    int   hist[$];      // model window, oldest at the front
    exp_t expq[$];      // results the DUT still owes
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_rst = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mode of the model window; lowest class wins a tie
    function automatic exp_t predict();
        int   cnt[NUM_CLS];
        exp_t e;
        foreach (cnt[c]) cnt[c] = 0;
        foreach (hist[k]) cnt[hist[k]]++;
        e.cls = 0;
        for (int c = 1; c < NUM_CLS; c++)
            if (cnt[c] > cnt[e.cls]) e.cls = c;
        e.conf = cnt[e.cls];
        e.full = (hist.size() == WINDOW) ? 1 : 0;
        return e;
    endfunction

    // Monitor: inputs and outputs are stable at the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
            expq.delete();
            chk("in_ready_in_reset", int'(in_ready), 0);
        end else begin
            automatic bit   mdl_valid = (expq.size() != 0);
            automatic bit   exp_ready = prev_rst && !flush && (!mdl_valid || out_ready);
            automatic exp_t e;
            chk("in_ready", int'(in_ready), int'(exp_ready));
            if (mdl_valid || out_valid) begin
                chk("out_valid", int'(out_valid), int'(mdl_valid));
                if (mdl_valid && out_valid) begin
                    chk("out_cls", int'(out_cls), expq[0].cls);
                    chk("out_full", int'(out_full), expq[0].full);
`ifdef DTC_VOTE_CONF_EN
                    chk("out_conf", int'(out_conf), expq[0].conf);
                    chk("out_unanim", int'(out_unanim), (expq[0].conf == WINDOW) ? 1 : 0);
`endif
                end
                if (mdl_valid && out_ready) void'(expq.pop_front());
            end
            if (flush) begin
                hist.delete();
                expq.delete();
            end else if (in_valid && exp_ready) begin
                hist.push_back(int'(in_cls));
                if (hist.size() > WINDOW) void'(hist.pop_front());
                e = predict();
                expq.push_back(e);
            end
        end
        prev_rst = rst_n;
    end

    // One cycle of stimulus, inputs applied just after the rising edge
    task automatic step(input bit v, input int c, input bit r, input bit f);
        in_valid  = v;
        in_cls    = CLASS_W'(c);
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int plan [11] = '{1, 1, 2, 1, 3, 1, 2, 2, 2, 2, 2};
        int fav;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_cls    = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_cls", int'(out_cls), 0);
        chk("rst_out_full", int'(out_full), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", int'(in_ready), 1);

        // Fill then slide with the fixed class sequence
        foreach (plan[i]) step(1'b1, plan[i], 1'b1, 1'b0);

        // Backpressure: result held, input stalled
        for (int i = 0; i < 5; i++) step(1'b1, 4, 1'b0, 1'b0);
        step(1'b1, 4, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Flush mid-RUN with a colliding sample, then partial refill
        step(1'b1, 6, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 6, 1'b1, 1'b0);

        // Same-class replacement in a unanimous window
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < WINDOW + 2; i++) step(1'b1, 5, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomised traffic with a drifting favourite class
        fav = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) fav = $urandom_range(0, NUM_CLS - 1);
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) != 0) ? fav : $urandom_range(0, NUM_CLS - 1),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) == 0);
        end

        // Asynchronous reset between edges while streaming
        for (int i = 0; i < 10; i++) step(1'b1, $urandom_range(0, NUM_CLS - 1), 1'b1, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_in_ready", int'(in_ready), 0);
        chk("async_rst_out_full", int'(out_full), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(1'b1, 7, 1'b1, 1'b0);

        // Drain
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
